// File: rtl/spi_pkg.sv
// Shared types for the SPI target byte engine.
//   spi_tgt_state_t : frame state (IDLE / SELECTED)
//   SPI_BYTE_W      : width of one SPI byte
package spi_pkg;
  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    SELECTED = 1'b1
  } spi_tgt_state_t;
endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input.
//   clk_i    : destination clock
//   reset_ni : async active-low reset, loads RST_VAL into every stage
//   d        : asynchronous input
//   q        : synchronized output (STAGES clk_i cycles of latency)
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] pipe;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) pipe <= {STAGES{RST_VAL}};
    else           pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];
endmodule

// File: rtl/spi_target_engine.sv
// SPI mode-0 target byte engine, MSB first, pins oversampled in clk_i.
//   spi_sck_i/spi_csb_i/spi_mosi_i : asynchronous SPI pins from the controller
//   spi_miso_o/spi_miso_oe_o       : MISO data and enable (enabled while selected)
//   tx_data_i/tx_valid_i/tx_ready_o: one-deep TX holding buffer, valid/ready
//   rx_data_o/rx_valid_o           : received byte, one-cycle valid pulse
//   tx_underrun_o                  : pulse when FILL_BYTE had to be loaded
//   frame_abort_o                  : pulse when CSB rose mid-byte
//   busy_o                         : high while selected
module spi_target_engine
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  spi_sck_i,
  input  logic                  spi_csb_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [SPI_BYTE_W-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [SPI_BYTE_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  frame_abort_o,
  output logic                  busy_o
);
  logic sck_s, csb_s, mosi_s;
  logic sck_q, csb_q;

  // CSB idles high, so its synchronizer and history reset high: no false
  // edge is seen when reset releases with the target deselected.
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .reset_ni(reset_ni), .d(spi_sck_i), .q(sck_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .clk_i(clk_i), .reset_ni(reset_ni), .d(spi_csb_i), .q(csb_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .reset_ni(reset_ni), .d(spi_mosi_i), .q(mosi_s));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sck_q <= 1'b0;
      csb_q <= 1'b1;
    end else begin
      sck_q <= sck_s;
      csb_q <= csb_s;
    end
  end

  logic sck_rise, sck_fall, csb_rise, csb_fall;
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign csb_rise = csb_s & ~csb_q;
  assign csb_fall = ~csb_s & csb_q;

  spi_tgt_state_t state_q, state_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (csb_fall) state_d = SELECTED;
      SELECTED: if (csb_rise) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  logic                  sel;
  logic [SPI_BYTE_W-1:0] rx_shift, tx_shift, tx_buf;
  logic [2:0]            bit_cnt;
  logic                  tx_full;
  logic                  load_pend;  // 8th rise seen, next fall loads a byte
  logic                  load, accept;

  assign sel           = (state_q == SELECTED);
  assign spi_miso_oe_o = sel;
  assign busy_o        = sel;
  assign tx_ready_o    = ~tx_full;
  assign accept        = tx_valid_i & ~tx_full;
  assign load          = (~sel & csb_fall) | (sel & sck_fall & load_pend);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_shift      <= '0;
      tx_shift      <= '0;
      tx_buf        <= '0;
      tx_full       <= 1'b0;
      bit_cnt       <= '0;
      load_pend     <= 1'b0;
      spi_miso_o    <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_abort_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_abort_o <= 1'b0;

      // A write into an empty buffer survives a same-cycle load: the load
      // branch below only clears tx_full when the buffer was already full.
      if (accept) begin
        tx_buf  <= tx_data_i;
        tx_full <= 1'b1;
      end

      if (sel && csb_rise) begin
        bit_cnt       <= '0;
        rx_shift      <= '0;
        load_pend     <= 1'b0;
        spi_miso_o    <= 1'b0;
        frame_abort_o <= (bit_cnt != 3'd0);
      end else begin
        if (load) begin
          if (tx_full) begin
            tx_shift   <= tx_buf;
            tx_full    <= 1'b0;
            spi_miso_o <= tx_buf[SPI_BYTE_W-1];
          end else begin
            tx_shift      <= FILL_BYTE;
            tx_underrun_o <= 1'b1;
            spi_miso_o    <= FILL_BYTE[SPI_BYTE_W-1];
          end
        end

        if (sel && sck_rise) begin
          rx_shift <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_o  <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
            rx_valid_o <= 1'b1;
            load_pend  <= 1'b1;
          end
        end

        if (sel && sck_fall) begin
          if (load_pend) begin
            load_pend <= 1'b0;
          end else begin
            tx_shift   <= tx_shift << 1;
            spi_miso_o <= tx_shift[SPI_BYTE_W-2];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_target_engine.sv
// Self-checking bench for spi_target_engine: directed frames plus random
// frames, checked against a byte-level model of the TX buffer and frame rules.
module tb_spi_target_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck, csb, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_abort, busy;

  spi_target_engine #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .spi_sck_i(sck), .spi_csb_i(csb), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_underrun_o(tx_underrun), .frame_abort_o(frame_abort), .busy_o(busy));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // pulse monitor, sampled on the falling clk edge
  logic [7:0] rx_log [0:255];
  int rx_cnt = 0, und_cnt = 0, abt_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[7:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_underrun) und_cnt <= und_cnt + 1;
    if (frame_abort) abt_cnt <= abt_cnt + 1;
  end

  // byte-level model: one-deep TX buffer, FILL on empty load
  bit         mbuf_v = 1'b0;
  logic [7:0] mbuf_d;
  int         exp_und = 0;

  function automatic logic [7:0] model_load();
    if (mbuf_v) begin
      mbuf_v = 1'b0;
      return mbuf_d;
    end
    exp_und++;
    return 8'hFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    chk("tx_ready_before_write", tx_ready, !mbuf_v);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    mbuf_v   = 1'b1;
    mbuf_d   = d;
  endtask

  // SCK half period = 4 clk cycles (clk/8); MISO sampled just before each rise
  task automatic shift_bits(input logic [7:0] mo, input int nbits, input bit wr,
                            input logic [7:0] wd, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      if (wr && i == 2) begin tx_write(wd); tick(3); end
      else tick(4);
      mi[7-i] = miso;
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    tick(4);
  endtask

  logic [7:0] fm  [0:3];
  bit         fw  [0:3];
  logic [7:0] fwd [0:3];

  task automatic run_frame(input int nb, input int last_bits);
    int rx0, u0, a0, eu0, full, bits, sh;
    logic [7:0] em, mi;
    rx0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt; eu0 = exp_und; full = 0;
    csb = 1'b0;
    em = model_load();
    tick(6);
    chk("busy_selected", busy, 1'b1);
    chk("oe_selected", miso_oe, 1'b1);
    for (int b = 0; b < nb; b++) begin
      bits = (b == nb - 1 && last_bits != 0) ? last_bits : 8;
      shift_bits(fm[b], bits, fw[b] && !mbuf_v, fwd[b], mi);
      if (bits == 8) begin
        chk("miso_byte", mi, em);
        full++;
        em = model_load();
      end else begin
        sh = 8 - bits;
        chk("miso_partial", mi >> sh, em >> sh);
      end
    end
    csb = 1'b1;
    tick(8);
    chk("rx_pulse_count", rx_cnt - rx0, full);
    for (int k = 0; k < full; k++) chk("rx_byte", rx_log[(rx0 + k) % 256], fm[k]);
    chk("underrun_count", und_cnt - u0, exp_und - eu0);
    chk("abort_count", abt_cnt - a0, (last_bits != 0 && last_bits != 8) ? 1 : 0);
    chk("busy_idle", busy, 1'b0);
    chk("oe_idle", miso_oe, 1'b0);
    chk("tx_ready_idle", tx_ready, !mbuf_v);
  endtask

  task automatic clr_frame();
    for (int i = 0; i < 4; i++) begin
      fm[i] = 8'h00; fw[i] = 1'b0; fwd[i] = 8'h00;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_miso", miso, 1'b0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_underrun", tx_underrun, 1'b0);
    chk("rst_abort", frame_abort, 1'b0);
    chk("rst_busy", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] mi;
    int nb, lb;
    rst_n = 1'b0; sck = 1'b0; csb = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    tick(3);
    chk_reset_vals();
    rst_n = 1'b1;
    tick(4);

    // T1: preloaded 3C, receive A5
    clr_frame(); fm[0] = 8'hA5;
    tx_write(8'h3C);
    chk("tx_ready_after_write", tx_ready, 1'b0);
    run_frame(1, 0);
    chk("rx_data_hold", rx_data, 8'hA5);

    // T2: 01,FE with 55 preloaded, AA written during byte 0, 00 during byte 1
    clr_frame(); fm[0] = 8'h01; fm[1] = 8'hFE;
    fw[0] = 1'b1; fwd[0] = 8'hAA; fw[1] = 1'b1; fwd[1] = 8'h00;
    tx_write(8'h55);
    run_frame(2, 0);

    // drain the leftover byte so the buffer is empty for T3
    clr_frame(); fm[0] = 8'h11;
    run_frame(1, 0);

    // T3: nothing loaded at CSB fall -> FF; a mid-byte write covers the boundary
    clr_frame(); fm[0] = 8'h42; fw[0] = 1'b1; fwd[0] = 8'h99;
    run_frame(1, 0);

    // T4: abort after 5 bits, then a full 3C frame
    clr_frame(); fm[0] = 8'hB7;
    run_frame(1, 5);
    clr_frame(); fm[0] = 8'h3C;
    run_frame(1, 0);

    // T5: reset mid-byte
    tx_write(8'h81);
    csb = 1'b0;
    tick(6);
    shift_bits(8'h5A, 3, 1'b0, 8'h00, mi);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    csb = 1'b1; sck = 1'b0;
    mbuf_v = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_ready", tx_ready, 1'b1);
    clr_frame(); fm[0] = 8'h96;
    run_frame(1, 0);

    // T6: tx_valid held while not ready -> second byte dropped
    tx_write(8'hC3);
    tx_data = 8'h7E; tx_valid = 1'b1;
    tick(4);
    chk("tx_ready_held_full", tx_ready, 1'b0);
    tx_valid = 1'b0;
    clr_frame(); fm[0] = 8'h24;
    run_frame(1, 0);
    clr_frame(); fm[0] = 8'hE1;
    run_frame(1, 0);

    // random frames
    for (int f = 0; f < 16; f++) begin
      clr_frame();
      nb = $urandom_range(1, 3);
      lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      for (int b = 0; b < nb; b++) begin
        fm[b]  = 8'($urandom);
        fw[b]  = 1'($urandom_range(0, 1));
        fwd[b] = 8'($urandom);
      end
      if (!mbuf_v && $urandom_range(0, 1) == 1) tx_write(8'($urandom));
      run_frame(nb, lb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
